// File: rtl/as_seq_pkg.sv
// Shared types and instruction-field layout for the accumulator-processor sequencer.
package as_seq_pkg;

  localparam int IR_W   = 16;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  // Defined opcodes; 9..15 are undefined and execute as NOP with an illegal pulse.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_MAC  = 4'd2,
    OP_ACC  = 4'd3,
    OP_IN   = 4'd4,
    OP_BZ   = 4'd5,
    OP_BSW  = 4'd6,
    OP_JMP  = 4'd7,
    OP_HALT = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_IN
  } state_e;

  // Opcode field of an instruction word.
  function automatic logic [3:0] op_of(input logic [IR_W-1:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/as_pc.sv
// Program counter: reset, increment, pc-relative branch (pc+1+offset) and absolute load.
module as_pc #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             rel_load,
  input  logic             abs_load,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  abs_val,
  output logic [PC_W-1:0]  pc
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;

  assign pc_inc  = pc + PC_W'(1);
  // Two's-complement offset, sign-extended then trimmed to the pc width; sums wrap.
  assign off_ext = PC_W'(32'(signed'(offset)));

  // Absolute load wins over relative load, which wins over a plain increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= '0;
    else if (abs_load) pc <= abs_val;
    else if (rel_load) pc <= pc_inc + off_ext;
    else if (inc)      pc <= pc_inc;
  end

endmodule

// File: rtl/as_sequencer.sv
// Fetch/decode/execute controller for the accumulator processor.
// Controls are decoded from the ROM word at the end of DECODE so they are
// registered and stable for the whole EXEC cycle, where the ALU produces z.
module as_sequencer
  import as_seq_pkg::*;
#(
  parameter int n    = 8,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     instr,
  input  logic            in_valid,
  input  logic            z,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rd_addr,
  output logic [1:0]      rs_addr,
  output logic            reg_we,
  output logic [n-1:0]    immediate,
  output logic            add_a_sel,
  output logic            add_b_sel,
  output logic            acc_en,
  output logic            acc_add,
  output logic            in_en,
  output logic            halted,
  output logic            illegal
);

  state_e          state;
  logic [IR_W-1:0] ir;
  logic [3:0]      ir_op;
  logic [3:0]      dec_op;
  logic            reg_we_q;

  logic            pc_inc;
  logic            pc_rel;
  logic            pc_abs;
  logic [PC_W-1:0] pc_abs_val;

  assign ir_op   = op_of(ir);
  assign dec_op  = op_of(instr);
  assign rd_addr = ir[RD_HI:RD_LO];
  assign rs_addr = ir[RS_HI:RS_LO];

  // The IN write must land in the very cycle the switch strobe arrives, so that
  // path bypasses the register.
  assign reg_we = reg_we_q | ((state == S_WAIT_IN) & in_valid);

  // Next-pc selection; branches resolve on the live z during EXEC.
  always_comb begin
    pc_inc     = 1'b0;
    pc_rel     = 1'b0;
    pc_abs     = 1'b0;
    pc_abs_val = '0;
    case (state)
      S_IDLE:    if (run) pc_abs = 1'b1;
      S_EXEC: begin
        case (ir_op)
          OP_IN, OP_HALT: ;
          OP_BZ:   if (z) pc_rel = 1'b1; else pc_inc = 1'b1;
          OP_BSW:  if (!z) pc_rel = 1'b1; else pc_inc = 1'b1;
          OP_JMP: begin
            pc_abs     = 1'b1;
            pc_abs_val = PC_W'(ir[IMM_HI:IMM_LO]);
          end
          default: pc_inc = 1'b1;
        endcase
      end
      S_WAIT_IN: if (in_valid) pc_inc = 1'b1;
      default: ;
    endcase
  end

  as_pc #(.PC_W(PC_W), .OFF_W(IMM_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .rel_load (pc_rel),
    .abs_load (pc_abs),
    .offset   (ir[IMM_HI:IMM_LO]),
    .abs_val  (pc_abs_val),
    .pc       (pc)
  );

  // Sequencer FSM with registered ALU controls; controls default to 0 each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      reg_we_q  <= 1'b0;
      immediate <= '0;
      add_a_sel <= 1'b0;
      add_b_sel <= 1'b0;
      acc_en    <= 1'b0;
      acc_add   <= 1'b0;
      in_en     <= 1'b0;
    end else begin
      illegal   <= 1'b0;
      reg_we_q  <= 1'b0;
      immediate <= '0;
      add_a_sel <= 1'b0;
      add_b_sel <= 1'b0;
      acc_en    <= 1'b0;
      acc_add   <= 1'b0;
      in_en     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= instr;
          state <= S_EXEC;
          case (dec_op)
            OP_NOP, OP_JMP, OP_HALT: ;
            OP_ADDI: begin
              add_b_sel <= 1'b1;
              immediate <= n'(instr[IMM_HI:IMM_LO]);
              reg_we_q  <= 1'b1;
            end
            OP_MAC: begin
              immediate <= n'(instr[IMM_HI:IMM_LO]);
              reg_we_q  <= 1'b1;
            end
            OP_ACC: begin
              acc_add   <= 1'b1;
              acc_en    <= 1'b1;
              immediate <= n'(instr[IMM_HI:IMM_LO]);
            end
            OP_IN:  in_en <= 1'b1;
            OP_BZ:  add_b_sel <= 1'b1;
            OP_BSW: begin
              add_a_sel <= 1'b1;
              add_b_sel <= 1'b1;
            end
            default: illegal <= 1'b1;
          endcase
        end
        S_EXEC: begin
          case (ir_op)
            OP_IN: begin
              in_en <= 1'b1;
              state <= S_WAIT_IN;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_IDLE;
            end
            default: state <= S_FETCH;
          endcase
        end
        S_WAIT_IN: begin
          if (in_valid) state <= S_FETCH;
          else          in_en <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
